// File: rtl/obstacle_field.sv
// obstacle_field
//   Scrolling obstacle playfield for the frogger-style collision checker.
//   Keeps an 8x8 grid: rows 0 and 7 are safe (always zero), rows 1-6 are
//   traffic lanes. Lanes shift on a divided "scroll tick". Fast lanes
//   (1,3,5) move every tick and slow lanes (2,4,6) move every other tick.
//   New cells enter each lane from a 16-bit Fibonacci LFSR
//   (x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0).
//
// Optional feature (compile-time macro OBS_GAP_EN):
//   Each lane keeps a 2-bit history of its last inserted bits and suppresses
//   a third consecutive obstacle, so every lane stays passable.
//
// Parameters:
//   TICK_DIV   clock cycles per scroll tick (>= 2)
//   LFSR_SEED  nonzero LFSR value loaded on reset
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   enable     1 = scroll; 0 = freeze field and divider
//   resetGame  synchronous clear of the field (LFSR keeps running state)
//   obsMove    registered grid, obsMove[r][c] = 1 -> obstacle in that cell
//   step       one-cycle pulse in the cycle obsMove shows a new scroll
module obstacle_field #(
  parameter int unsigned TICK_DIV  = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            resetGame,
  output logic [7:0][7:0] obsMove,
  output logic            step
);

  localparam int unsigned   CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            phase_q, phase_d;
  logic [15:0]     lfsr_q,  lfsr_d;
  logic [7:0][7:0] grid_q,  grid_d;
  logic            step_q,  step_d;
`ifdef OBS_GAP_EN
  logic [6:1][1:0] hist_q,  hist_d;
`endif

  logic        tick;
  logic        lfsr_fb;
  logic [15:0] lfsr_adv;

  assign tick     = enable && (cnt_q == CNT_LAST);
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // An all-zero LFSR would stick forever; reload the seed instead.
  assign lfsr_adv = (lfsr_q == '0) ? LFSR_SEED : {lfsr_q[14:0], lfsr_fb};

  always_comb begin
    logic ins;
    ins     = 1'b0;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    lfsr_d  = lfsr_q;
    grid_d  = grid_q;
    step_d  = 1'b0;
`ifdef OBS_GAP_EN
    hist_d  = hist_q;
`endif
    if (resetGame) begin
      // Collision clear wins over a coincident tick; LFSR is left running.
      cnt_d   = '0;
      phase_d = 1'b0;
      grid_d  = '0;
`ifdef OBS_GAP_EN
      hist_d  = '0;
`endif
    end else if (enable) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        step_d  = 1'b1;
        lfsr_d  = lfsr_adv;
        for (int unsigned r = 1; r <= 6; r++) begin
          // Slow lanes move only when phase (before toggling) is 1.
          if ((r % 2 == 1) || phase_q) begin
            // Insert bit is taken from the pre-advance LFSR.
            ins = lfsr_q[2*r-1];
`ifdef OBS_GAP_EN
            ins       = ins & ~(hist_q[r][1] & hist_q[r][0]);
            hist_d[r] = {hist_q[r][0], ins};
`endif
            if (r % 2 == 1) grid_d[r] = {grid_q[r][6:0], ins};
            else            grid_d[r] = {ins, grid_q[r][7:1]};
          end
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    grid_d[0] = '0;
    grid_d[7] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      grid_q  <= '0;
      step_q  <= 1'b0;
`ifdef OBS_GAP_EN
      hist_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      grid_q  <= grid_d;
      step_q  <= step_d;
`ifdef OBS_GAP_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign obsMove = grid_q;
  assign step    = step_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Scoreboard bench for obstacle_field (TICK_DIV = 4, seed 16'hACE1).
// The driver advances a small behavioural model at every rising edge and
// pushes {edge number, grid} whenever a scroll is due; the first three
// scrolls use hand-computed values. A negedge monitor compares step and
// obsMove against the queue.
module tb_obstacle_field;

  localparam int unsigned TD   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            resetGame;
  logic [7:0][7:0] obsMove;
  logic            step;

  obstacle_field #(.TICK_DIV(TD), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .resetGame (resetGame),
    .obsMove   (obsMove),
    .step      (step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] grid;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;
  int   triples  = 0;

  // hand-computed first three scrolls after reset release
  int          hand_cyc  [0:2] = '{4, 8, 12};
  logic [63:0] hand_grid [0:2] = '{64'h0000_0000_0100_0000,
                                   64'h0080_0080_0200_0100,
                                   64'h0080_0180_0400_0300};
  int          hand_left = 3;

  // behavioural model
  logic [7:0]  m_lane [1:6];
  logic [1:0]  m_hist [1:6];
  logic [15:0] m_lfsr;
  int          m_cnt;
  bit          m_phase;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] m_pack();
    return {8'h00, m_lane[6], m_lane[5], m_lane[4], m_lane[3], m_lane[2], m_lane[1], 8'h00};
  endfunction

  function automatic bit has_triple(input logic [7:0] r);
    for (int i = 0; i < 6; i++)
      if (r[i] && r[i+1] && r[i+2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int ln = 1; ln <= 6; ln++) begin
      m_lane[ln] = 8'h00;
      m_hist[ln] = 2'b00;
    end
    m_cnt   = 0;
    m_phase = 1'b0;
  endtask

  task automatic model_tick();
    for (int ln = 1; ln <= 6; ln++) begin
      if ((ln % 2 == 1) || m_phase) begin
        logic b;
        b = m_lfsr[2*ln-1];
`ifdef OBS_GAP_EN
        if (m_hist[ln] == 2'b11) b = 1'b0;
        m_hist[ln] = {m_hist[ln][0], b};
`endif
        if (ln % 2 == 1) m_lane[ln] = (m_lane[ln] << 1) | {7'd0, b};
        else             m_lane[ln] = (m_lane[ln] >> 1) | {b, 7'd0};
      end
    end
    if (m_lfsr == 16'h0000) m_lfsr = SEED;
    else                    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    m_phase = !m_phase;
  endtask

  task automatic model_edge(input logic en, input logic rg);
    exp_t e;
    edges++;
    if (rg) begin
      model_clear();
    end else if (en) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        model_tick();
        if (hand_left > 0) begin
          e.cyc  = hand_cyc[3 - hand_left];
          e.grid = hand_grid[3 - hand_left];
          hand_left--;
        end else begin
          e.cyc  = edges;
          e.grid = m_pack();
        end
        q.push_back(e);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drive(input logic en, input logic rg);
    enable    = en;
    resetGame = rg;
    @(posedge clk);
    model_edge(en, rg);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    bit expect_step;
    exp_t e;
    chk("safe_rows", {obsMove[7], obsMove[0]}, 16'h0000);
    while (q.size() > 0 && q[0].cyc < edges) begin
      e = q.pop_front();
      chk("missed_step", 64'(0), 64'(e.cyc));
    end
    expect_step = (q.size() > 0) && (q[0].cyc == edges);
    chk("step", 64'(step), 64'(expect_step));
    if (expect_step) begin
      e = q.pop_front();
      if (step) chk("grid", obsMove, e.grid);
    end
    if (step)
      for (int r = 1; r <= 6; r++)
        if (has_triple(obsMove[r])) triples++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    resetGame = 1'b0;
    m_lfsr    = SEED;
    model_clear();
    #12;
    chk("reset_grid", obsMove, 64'h0);
    chk("reset_step", 64'(step), 64'h0);
    reset = 1'b0;

    // cadence and first-tick content (hand-computed)
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);

    // asynchronous reset mid-cycle while step is high and field non-zero
    #6;
    chk("pre_reset_step", 64'(step), 64'h1);
    chk("pre_reset_grid", obsMove, 64'h0080_0180_0400_0300);
    reset = 1'b1;
    #1;
    chk("async_reset_grid", obsMove, 64'h0);
    chk("async_reset_step", 64'(step), 64'h0);
    m_lfsr = SEED;
    model_clear();
    q.delete();
    @(posedge clk);
    edges++;
    #1;
    reset = 1'b0;

    // disabled after reset: nothing moves
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0);
    chk("disabled_hold", obsMove, 64'h0);

    // freeze mid-count
    for (int i = 0; i < 22; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    chk("freeze_grid", obsMove, m_pack());
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);

    // collision clear at count 2
    for (int k = 0; k < 2 * TD && m_cnt != 2; k++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    chk("clear_grid", obsMove, 64'h0);
    chk("clear_step", 64'(step), 64'h0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);

    // collision coincident with a tick
    for (int k = 0; k < 2 * TD && m_cnt != TD - 1; k++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    chk("clear_tick_grid", obsMove, 64'h0);
    chk("clear_tick_step", 64'(step), 64'h0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);

    // long run: 500 scrolls
    triples = 0;
    for (int i = 0; i < 500 * TD; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'h0);
`ifdef OBS_GAP_EN
    chk("gap_no_triples", 64'(triples), 64'h0);
`else
    chk("triples_seen", 64'(triples > 0), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
